// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 frame scheduler and its serializer.
// Holds the sequencer state encoding, GRB field layout, timing defaults and the brightness scaler.
package ws2812_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SCALE,
        START,
        WAIT,
        LATCH
    } state_e;

    localparam int PIX_W = 24;
    localparam int G_HI  = 23;
    localparam int G_LO  = 16;
    localparam int R_HI  = 15;
    localparam int R_LO  = 8;
    localparam int B_HI  = 7;
    localparam int B_LO  = 0;

    // Timing in 50 MHz clk cycles (20 ns each).
    localparam int RES_CYCLES_DEF = 3000;
    localparam int T0H_CYCLES     = 20;
    localparam int T0L_CYCLES     = 43;
    localparam int T1H_CYCLES     = 40;
    localparam int T1L_CYCLES     = 23;

    // brightness+1 keeps 255 as the identity; the product fits in 16 bits.
    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = {8'd0, c} * ({8'd0, b} + 16'd1);
        return p[15:8];
    endfunction

    function automatic logic [PIX_W-1:0] scale_grb(input logic [PIX_W-1:0] grb, input logic [7:0] b);
        return {scale_ch(grb[G_HI:G_LO], b), scale_ch(grb[R_HI:R_LO], b), scale_ch(grb[B_HI:B_LO], b)};
    endfunction

endpackage

// File: rtl/ws2812_frame_buf.sv
// Two-bank pixel store: simple dual-port RAM with one-cycle synchronous read.
// The address MSB selects the bank; contents are not reset.
module ws2812_frame_buf
    import ws2812_pkg::*;
#(
    parameter int AW = 7
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [PIX_W-1:0] rdata
);
    logic [PIX_W-1:0] mem [2**AW];
    logic [PIX_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// Frame sequencer: streams the front bank, brightness-scaled, to the pixel serializer,
// then holds the latch gap. Host writes land in the back bank; commit swaps banks between frames.
module ws2812_frame_scheduler
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS       = 64,
    parameter int ADDR_W         = 6,
    parameter int RES_CYCLES     = RES_CYCLES_DEF,
    parameter int REFRESH_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_grb,
    input  logic              commit,
    input  logic              frame_start,
    input  logic [7:0]        brightness,
    output logic              px_start,
    output logic [23:0]       px_grb,
    input  logic              px_done,
    output logic              busy,
    output logic              frame_done,
    output logic              swap_pending,
    output logic              active_bank,
    output state_e            state_dbg
);
    localparam logic [ADDR_W:0]   NUM_LEDS_W = (ADDR_W + 1)'(NUM_LEDS);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_LEDS - 1);
    localparam logic [31:0]       RES_LAST   = 32'(RES_CYCLES - 1);
    localparam bit                REF_EN     = (REFRESH_CYCLES > 0);
    localparam logic [31:0]       REF_LAST   = REF_EN ? 32'(REFRESH_CYCLES - 1) : 32'd0;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       lat_q, lat_d;
    logic [31:0]       ref_q, ref_d;
    logic [7:0]        bright_q, bright_d;
    logic [23:0]       grb_q, grb_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              pend_q, pend_d;
    logic              bank_q, bank_d;

    logic [23:0]       rd_data;
    logic              wr_ok, trigger, frame_end, apply;

    assign wr_ok = wr_en && ({1'b0, wr_addr} < NUM_LEDS_W);

    ws2812_frame_buf #(.AW(ADDR_W + 1)) u_buf (
        .clk   (clk),
        .we    (wr_ok),
        .waddr ({~bank_q, wr_addr}),
        .wdata (wr_grb),
        .raddr ({bank_q, idx_q}),
        .rdata (rd_data)
    );

    // Serializer handshake: px_start is a one-cycle request with px_grb held until
    // px_done; a px_done is only honoured in WAIT and never in the px_start cycle.
    always_comb begin
        trigger   = frame_start || (REF_EN && (ref_q == REF_LAST));
        frame_end = (state_q == LATCH) && (lat_q == RES_LAST);
        // A swap requested together with a start is applied first so the frame uses the new bank.
        apply     = ((state_q == IDLE) && (pend_q || (commit && trigger)))
                  || (frame_end && (pend_q || commit));
        pend_d    = apply ? 1'b0 : (pend_q || commit);
        bank_d    = bank_q ^ apply;

        state_d  = state_q;
        idx_d    = idx_q;
        lat_d    = lat_q;
        ref_d    = 32'd0;
        bright_d = bright_q;
        grb_d    = grb_q;
        start_d  = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                ref_d = REF_EN ? ref_q + 32'd1 : 32'd0;
                if (trigger) begin
                    state_d  = FETCH;
                    idx_d    = '0;
                    bright_d = brightness;
                    ref_d    = 32'd0;
                end
            end
            FETCH: state_d = SCALE;
            SCALE: begin
                grb_d   = scale_grb(rd_data, bright_q);
                state_d = START;
            end
            START: begin
                start_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (px_done && !start_q) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = LATCH;
                        lat_d   = 32'd0;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            LATCH: begin
                if (frame_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    lat_d   = 32'd0;
                end else begin
                    lat_d = lat_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            lat_q    <= 32'd0;
            ref_q    <= 32'd0;
            bright_q <= 8'd0;
            grb_q    <= 24'd0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            pend_q   <= 1'b0;
            bank_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            lat_q    <= lat_d;
            ref_q    <= ref_d;
            bright_q <= bright_d;
            grb_q    <= grb_d;
            start_q  <= start_d;
            done_q   <= done_d;
            pend_q   <= pend_d;
            bank_q   <= bank_d;
        end
    end

    assign px_start     = start_q;
    assign px_grb       = grb_q;
    assign busy         = (state_q != IDLE);
    assign frame_done   = done_q;
    assign swap_pending = pend_q;
    assign active_bank  = bank_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Bench for ws2812_frame_scheduler: random pixels and brightness checked against a
// frame-level model (two pixel banks, scaling arithmetic, cycle timing rules).
module tb_ws2812_frame_scheduler;
  import ws2812_pkg::*;

  localparam int NL  = 4;
  localparam int AW  = 3;
  localparam int RES = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (no auto-refresh) ----------------
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [23:0]   wr_grb = '0;
  logic          commit = 1'b0;
  logic          frame_start = 1'b0;
  logic [7:0]    brightness = 8'd0;
  logic          px_start, busy, frame_done, swap_pending, active_bank;
  logic [23:0]   px_grb;
  logic          px_done = 1'b0;
  state_e        state_dbg;

  ws2812_frame_scheduler #(.NUM_LEDS(NL), .ADDR_W(AW), .RES_CYCLES(RES), .REFRESH_CYCLES(0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_grb(wr_grb),
    .commit(commit), .frame_start(frame_start), .brightness(brightness),
    .px_start(px_start), .px_grb(px_grb), .px_done(px_done), .busy(busy),
    .frame_done(frame_done), .swap_pending(swap_pending), .active_bank(active_bank),
    .state_dbg(state_dbg)
  );

  // ---------------- DUT with auto-refresh ----------------
  logic        frame_start2 = 1'b0;
  logic        px_start2, busy2, frame_done2, swap_pending2, active_bank2;
  logic [23:0] px_grb2;
  logic        px_done2 = 1'b0;
  state_e      state_dbg2;

  ws2812_frame_scheduler #(.NUM_LEDS(NL), .ADDR_W(AW), .RES_CYCLES(RES), .REFRESH_CYCLES(50)) dut2 (
    .clk(clk), .rst_n(rst2_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_grb(wr_grb),
    .commit(commit), .frame_start(frame_start2), .brightness(brightness),
    .px_start(px_start2), .px_grb(px_grb2), .px_done(px_done2), .busy(busy2),
    .frame_done(frame_done2), .swap_pending(swap_pending2), .active_bank(active_bank2),
    .state_dbg(state_dbg2)
  );

  // ---------------- serializer models: px_done 10 cycles after px_start ----------------
  int ser_cnt = 0;
  bit inject_done = 1'b0;
  always begin
    @(posedge clk); #2;
    px_done = 1'b0;
    if (!rst_n) ser_cnt = 0;
    else begin
      if (ser_cnt > 0) begin
        ser_cnt--;
        if (ser_cnt == 0) px_done = 1'b1;
      end
      if (px_start) ser_cnt = 10;
      if (inject_done) begin
        px_done = 1'b1;
        inject_done = 1'b0;
      end
    end
  end

  int ser2_cnt = 0;
  always begin
    @(posedge clk); #2;
    px_done2 = 1'b0;
    if (!rst2_n) ser2_cnt = 0;
    else begin
      if (ser2_cnt > 0) begin
        ser2_cnt--;
        if (ser2_cnt == 0) px_done2 = 1'b1;
      end
      if (px_start2) ser2_cnt = 10;
    end
  end

  int fd2_q[$];
  int st2_q[$];
  always @(negedge clk) begin
    if (rst2_n) begin
      if (px_start2) st2_q.push_back(cyc);
      if (frame_done2) fd2_q.push_back(cyc);
    end
  end

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  logic [23:0] m_mem [2][NL];
  bit m_act = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] ref_scale(input logic [23:0] c, input int b);
    int g, r, bl;
    g  = (int'(c[23:16]) * (b + 1)) / 256;
    r  = (int'(c[15:8])  * (b + 1)) / 256;
    bl = (int'(c[7:0])   * (b + 1)) / 256;
    return {g[7:0], r[7:0], bl[7:0]};
  endfunction

  // ---------------- driver tasks (entered and left on a negedge) ----------------
  task automatic write_px(input int a, input logic [23:0] v);
    wr_en = 1'b1; wr_addr = AW'(a); wr_grb = v;
    @(negedge clk);
    wr_en = 1'b0;
    if (a < NL) m_mem[!m_act][a] = v;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    check("pend_set", swap_pending, 1);
    @(negedge clk);
    m_act = !m_act;
    check("pend_clr", swap_pending, 0);
    check("bank_swap", active_bank, m_act);
  endtask

  task automatic idle_check(input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (px_start || busy || frame_done) bad++;
    end
    check("no_extra_frame", bad, 0);
  endtask

  task automatic run_frame(input logic [7:0] br, input bit with_commit, input bit mid_commit,
                           input bit busy_start, input bit latch_inject);
    int st_q[$];
    int dn_q[$];
    logic [23:0] px_q[$];
    int t0, fd, cc, prev;
    bit got_fd, pend_ok, sent_busy;
    if (with_commit) m_act = !m_act;
    for (int i = 0; i < NL; i++) exp_q.push_back(ref_scale(m_mem[m_act][i], int'(br)));
    brightness = br; frame_start = 1'b1; commit = with_commit; t0 = cyc;
    got_fd = 0; fd = 0; cc = -1; pend_ok = 1; sent_busy = 0;
    for (int k = 0; k < 3000 && !got_fd; k++) begin
      @(negedge clk);
      frame_start = 1'b0; commit = 1'b0;
      brightness = 8'($urandom_range(0, 255));
      if (px_start) begin st_q.push_back(cyc); px_q.push_back(px_grb); end
      if (px_done && dn_q.size() < st_q.size()) dn_q.push_back(cyc);
      if (frame_done) begin
        got_fd = 1; fd = cyc;
        check("busy_at_done", busy, 0);
        if (mid_commit) begin
          m_act = !m_act;
          check("pend_at_done", swap_pending, 0);
        end
        check("bank_at_done", active_bank, m_act);
      end else if (cc >= 0 && cyc > cc && !swap_pending) pend_ok = 0;
      if (mid_commit && cc < 0 && dn_q.size() == 2) begin commit = 1'b1; cc = cyc; end
      if (busy_start && !sent_busy && st_q.size() == 1) begin frame_start = 1'b1; sent_busy = 1; end
      if (latch_inject && dn_q.size() == NL && cyc == dn_q[NL-1] + 5) inject_done = 1'b1;
    end
    frame_start = 1'b0; commit = 1'b0;
    if (!got_fd) check("frame_timeout", 0, 1);
    check("n_px", st_q.size(), NL);
    if (mid_commit) check("pend_held", pend_ok, 1);
    for (int i = 0; i < st_q.size() && exp_q.size() > 0; i++) begin
      check("px_grb", px_q[i], exp_q.pop_front());
      prev = (i == 0) ? t0 : ((i - 1 < dn_q.size()) ? dn_q[i-1] : -100);
      check("t_start", st_q[i], prev + 4);
    end
    exp_q.delete();
    if (got_fd && dn_q.size() == NL) check("t_done", fd, dn_q[NL-1] + 1 + RES);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_px_start", px_start, 0);
    check("rst_px_grb", px_grb, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_swap_pending", swap_pending, 0);
    check("rst_active_bank", active_bank, 0);
    rst_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);

    // Directed pixels, full brightness: identity.
    write_px(0, 24'h112233); write_px(1, 24'h445566);
    write_px(2, 24'h778899); write_px(3, 24'hAABBCC);
    do_commit();
    check("bank_after_commit", active_bank, 1);
    run_frame(8'd255, 0, 0, 0, 0);

    // Scaling corner values.
    write_px(0, 24'hFF8001);
    for (int i = 1; i < NL; i++) write_px(i, 24'($urandom));
    do_commit();
    check("scale_ref", ref_scale(m_mem[m_act][0], 127), 24'h7F4000);
    run_frame(8'd127, 0, 0, 0, 0);
    run_frame(8'd0, 0, 0, 0, 0);

    // Commit while a frame is in flight.
    for (int i = 0; i < NL; i++) write_px(i, 24'($urandom));
    run_frame(8'($urandom_range(0, 255)), 0, 1, 0, 0);

    // Dropped start while busy, stray done in latch gap, out-of-range write.
    write_px(5, 24'hDEAD00);
    run_frame(8'd255, 0, 0, 1, 1);
    idle_check(30);
    run_frame(8'd255, 0, 0, 0, 0);

    // Commit and start in the same idle cycle.
    for (int i = 0; i < NL; i++) write_px(i, 24'($urandom));
    run_frame(8'($urandom_range(0, 255)), 1, 0, 0, 0);

    // Asynchronous reset during WAIT of pixel 2.
    brightness = 8'd255; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    n = 0;
    for (int k = 0; k < 500 && n < 2; k++) begin
      if (px_start) n++;
      if (n < 2) @(negedge clk);
    end
    check("reset_reached_px2", n, 2);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_px_start", px_start, 0);
    check("arst_px_grb", px_grb, 0);
    check("arst_busy", busy, 0);
    check("arst_frame_done", frame_done, 0);
    check("arst_swap_pending", swap_pending, 0);
    check("arst_active_bank", active_bank, 0);
    check("arst_state", 32'(state_dbg), 32'(IDLE));
    m_act = 1'b0;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (px_start) n++;
    end
    check("arst_no_start", n, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(8'd255, 0, 0, 0, 0);

    // Random frames with random (sometimes ignored) writes.
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 6; w++) write_px($urandom_range(0, 7), 24'($urandom));
      do_commit();
      run_frame(8'($urandom_range(0, 255)), 0, 0, 0, 0);
    end

    // Auto-refresh instance: start follows each frame_done by a fixed gap.
    for (int k = 0; k < 2000 && fd2_q.size() < 3; k++) @(negedge clk);
    check("refresh_frames", fd2_q.size() >= 3, 1);
    for (int j = 0; j < fd2_q.size() && j < 2; j++) begin
      int nx;
      nx = -1;
      foreach (st2_q[m]) if (nx < 0 && st2_q[m] > fd2_q[j]) nx = st2_q[m];
      check("refresh_gap", nx - fd2_q[j], 53);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_scheduler.md
Name: ws2812_frame_scheduler

Overview:
- Frame-level sequencer for a WS2812 strip. Holds a double-buffered frame of NUM_LEDS 24-bit GRB pixels and applies global brightness scaling.
- Hands pixels one at a time to the single-pixel serializer over a start/done handshake, then holds the line idle for the latch gap.
- Sits between the host (register/bus side) and the pixel serializer that drives the data pin.

Parameters:
- NUM_LEDS, 64, pixels per frame (>=1)
- ADDR_W, 6, pixel address width; 2**ADDR_W >= NUM_LEDS
- RES_CYCLES, 3000, latch-gap length in clk cycles after the last pixel (>50 us at 50 MHz)
- REFRESH_CYCLES, 0, auto-refresh period in clk cycles, measured from frame_done; 0 disables auto-refresh

Ports:
- clk  in  1  clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  host pixel write strobe; writes go to the back bank
- wr_addr  in  ADDR_W  pixel index for the write
- wr_grb  in  24  pixel data {G,R,B}
- commit  in  1  pulse; requests a bank swap at the next frame boundary
- frame_start  in  1  pulse; requests transmission of the front bank
- brightness  in  8  global scale factor
- px_start  out  1  one-cycle pulse to the serializer
- px_grb  out  24  scaled pixel; stable from px_start until px_done
- px_done  in  1  one-cycle pulse from the serializer when its 24 bits are sent
- busy  out  1  high while a frame is in progress
- frame_done  out  1  one-cycle pulse at the end of the latch gap
- swap_pending  out  1  commit accepted, swap not yet performed
- active_bank  out  1  index of the front (transmitting) bank

Behaviour:
- Reset values: px_start=0, px_grb=0, busy=0, frame_done=0, swap_pending=0, active_bank=0; state IDLE; counters 0. Buffer RAM is not cleared.
- Reset mid-frame: everything above is restored immediately; no further px_start is issued.
- Writes:
  - Always accepted into bank ~active_bank, in any state.
  - wr_addr >= NUM_LEDS is ignored.
  - Write and read of the same bank never collide, by construction.
- Commit:
  - Sets swap_pending.
  - In IDLE, the swap happens the next cycle: active_bank toggles and swap_pending clears.
  - While busy, the swap is deferred to the cycle frame_done pulses; the frame in flight keeps its bank.
  - A repeated commit while pending is merged into the single pending swap.
- Start triggers: frame_start, or auto-refresh expiry (REFRESH_CYCLES>0, counter reaching REFRESH_CYCLES-1 while in IDLE).
  - A trigger while busy is dropped.
  - Commit and frame_start in the same IDLE cycle: swap first; the frame transmits the new bank.
- brightness is sampled once at frame start and held for the whole frame.
- Scaling per channel: out = (c * (brightness+1)) >> 8, with a 16-bit intermediate. brightness=255 is the identity; brightness=0 gives c>>8 = 0.
- FSM:
  - IDLE -> FETCH on trigger; busy=1 and pixel index=0.
  - FETCH: present the RAM read address (1-cycle read latency).
  - SCALE: register the scaled px_grb.
  - START: pulse px_start for one cycle.
  - WAIT: hold until px_done.
    - Pixel index < NUM_LEDS-1: increment the index, go to FETCH.
    - Otherwise go to LATCH.
  - LATCH: count RES_CYCLES cycles, then pulse frame_done with busy=0 in the same cycle, return to IDLE, and apply any pending swap.
- Latency:
  - px_start is asserted 3 cycles after a trigger is sampled.
  - The next px_start is asserted 3 cycles after each px_done.
- px_done outside WAIT is ignored. px_done coincident with px_start is ignored; a valid done is at least 1 cycle later.

Decomposition:
- Shared package ws2812_pkg:
  - state enum (IDLE, FETCH, SCALE, START, WAIT, LATCH)
  - GRB field offsets (G=23:16, R=15:8, B=7:0)
  - timing constants: RES_CYCLES default, serializer T0H/T0L/T1H/T1L
- One sub-module, ws2812_frame_buf: 2*NUM_LEDS x 24 simple dual-port RAM with synchronous read. Bank select is the address MSB.
- Scaling is inline combinational logic feeding the SCALE register.

Test Plan (bench: NUM_LEDS=4, RES_CYCLES=20, REFRESH_CYCLES=0, serializer model returning px_done 10 cycles after px_start):
- Write 0x112233, 0x445566, 0x778899, 0xAABBCC to addr 0-3, commit, frame_start with brightness=255 -> active_bank=1; four px_start pulses carrying exactly those values in order; frame_done 20 cycles after the 4th px_done; busy low in the same cycle.
- Same frame with brightness=127 and pixel 0xFF8001 -> px_grb=0x7F4000. With brightness=0 -> 0x000000.
- Commit mid-frame after the 2nd px_done -> pixels 3-4 still come from the old bank; swap_pending=1 until frame_done, then active_bank toggles.
- frame_start while busy, px_done while in LATCH, and a write to wr_addr=5 -> no extra frame, no state change, no RAM change; the next frame shows the unchanged pixels.
- Assert rst_n low during WAIT of pixel 2 -> all outputs 0 and active_bank=0 asynchronously; after release, frame_start sends 4 pixels from bank 0.
- REFRESH_CYCLES=50 -> the second frame's first px_start arrives exactly 53 cycles after the first frame_done.
